// File: rtl/alu_sequencer.sv
// Issue/writeback controller for a combinational 16-bit ALU: accepts one instruction,
// reads operands from an 8x16 register file, captures the ALU result and retires it.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  alu_s,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_f,
  input  logic        alu_ovf,
  input  logic        alu_take_branch,
  output logic [7:0]  pc,
  output logic        done,
  output logic        ovf_flag,
  output logic        illegal_flag,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StWrite} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] regs_q [8];
  logic [15:0] f_q;
  logic        ovf_q;
  logic        take_q;

  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [2:0]  br_rs;
  logic [7:0]  br_off;
  logic [15:0] imm;
  logic        is_alu;
  logic        is_br;
  logic        is_ldi;
  logic        is_add;
  logic [15:0] rs1_val;
  logic [15:0] rs2_val;
  logic [15:0] br_val;

  assign op     = instr_q[15:12];
  assign rd     = instr_q[11:9];
  assign rs1    = instr_q[8:6];
  assign rs2    = instr_q[5:3];
  assign br_rs  = instr_q[11:9];
  assign br_off = instr_q[7:0];
  assign imm    = {{7{instr_q[8]}}, instr_q[8:0]};

  always_comb begin
    is_alu = 1'b0;
    is_br  = 1'b0;
    is_ldi = 1'b0;
    unique case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8: is_alu = 1'b1;
      4'h6, 4'h7:                               is_br  = 1'b1;
      4'hF:                                     is_ldi = 1'b1;
      default: ;
    endcase
  end

  assign is_add = (op == 4'h0);

  // Register 0 is hard-wired to zero on every read port.
  assign rs1_val  = (rs1 == 3'd0) ? 16'h0000 : regs_q[rs1];
  assign rs2_val  = (rs2 == 3'd0) ? 16'h0000 : regs_q[rs2];
  assign br_val   = (br_rs == 3'd0) ? 16'h0000 : regs_q[br_rs];
  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs_q[dbg_addr];

  assign instr_ready = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (instr_valid) state_d = StIssue;
      StIssue:   state_d = StCapture;
      StCapture: state_d = StWrite;
      StWrite:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= 16'h0000;
      alu_s        <= 4'h0;
      alu_a        <= 16'h0000;
      alu_b        <= 16'h0000;
      f_q          <= 16'h0000;
      ovf_q        <= 1'b0;
      take_q       <= 1'b0;
      pc           <= 8'h00;
      done         <= 1'b0;
      ovf_flag     <= 1'b0;
      illegal_flag <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      done    <= (state_q == StWrite);

      if (state_q == StIdle && instr_valid) instr_q <= instr;

      if (state_q == StIssue) begin
        alu_s <= op;
        if (is_alu) begin
          alu_a <= rs1_val;
          alu_b <= rs2_val;
        end else if (is_br) begin
          alu_a <= br_val;
          alu_b <= 16'h0000;
        end else begin
          alu_a <= 16'h0000;
          alu_b <= 16'h0000;
        end
      end

      if (state_q == StCapture) begin
        f_q    <= alu_f;
        ovf_q  <= alu_ovf;
        take_q <= alu_take_branch;
      end

      if (state_q == StWrite) begin
        if (is_alu && rd != 3'd0) regs_q[rd] <= f_q;
        if (is_ldi && rd != 3'd0) regs_q[rd] <= imm;
        if (is_add) ovf_flag <= ovf_flag | ovf_q;
        if (!is_alu && !is_br && !is_ldi) illegal_flag <= 1'b1;
        // Taken branches are relative to the following instruction; wraps mod 256.
        if (is_br && take_q) pc <= pc + 8'd1 + br_off;
        else                 pc <= pc + 8'd1;
      end
    end
  end

endmodule
